// File: rtl/led_status_ctrl_if.sv
// Configuration/event bundle for led_status_ctrl: control logic drives it (master),
// the LED driver consumes it (slave).
interface led_status_ctrl_if #(
  parameter int N_CH     = 3,
  parameter int PWM_BITS = 4
);
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic                cfg_we;
  logic [CW-1:0]       cfg_ch;
  logic [2:0]          cfg_mode;
  logic [15:0]         cfg_period;
  logic [PWM_BITS-1:0] cfg_duty;
  logic [N_CH-1:0]     evt;

  modport master (
    output cfg_we, cfg_ch, cfg_mode, cfg_period, cfg_duty, evt
  );

  modport slave (
    input cfg_we, cfg_ch, cfg_mode, cfg_period, cfg_duty, evt
  );
endinterface

// File: rtl/led_status_ctrl.sv
// Multi-channel status-LED driver: OFF/ON/BLINK/PULSE/PWM/HEARTBEAT per channel,
// all slow timing derived from one shared prescaler tick.
module led_status_ctrl #(
  parameter int              N_CH        = 3,
  parameter int              CLK_FREQ_HZ = 156_250_000,
  parameter int              TICK_HZ     = 1000,
  parameter int              PWM_BITS    = 4,
  parameter logic [N_CH-1:0] ACTIVE_LOW  = '0,
  parameter logic [15:0]     RST_PERIOD  = 16'd500
) (
  input  logic              clk,
  input  logic              rst_b,
  led_status_ctrl_if.slave  cfg,
  output logic              tick,
  output logic [N_CH-1:0]   led
);

  localparam int            DIV      = CLK_FREQ_HZ / TICK_HZ;
  localparam int            PW       = $clog2(DIV);
  localparam int            CW       = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  typedef enum logic [2:0] {
    MODE_OFF   = 3'd0,
    MODE_ON    = 3'd1,
    MODE_BLINK = 3'd2,
    MODE_PULSE = 3'd3,
    MODE_PWM   = 3'd4,
    MODE_HBEAT = 3'd5
  } mode_e;

  logic [PW-1:0]       pre_cnt_q, pre_cnt_d;
  logic                tick_q, tick_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [N_CH-1:0]     led_q, led_d;
  logic [N_CH-1:0]     lit_w;

  // tick is registered from the next prescaler value so it is high exactly
  // while pre_cnt sits at DIV-1.
  always_comb begin
    pre_cnt_d = (pre_cnt_q == PRE_LAST) ? '0 : pre_cnt_q + 1'b1;
    tick_d    = (pre_cnt_d == PRE_LAST);
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    led_d     = lit_w ^ ACTIVE_LOW;
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      pre_cnt_q <= '0;
      tick_q    <= 1'b0;
      pwm_cnt_q <= '0;
      led_q     <= ACTIVE_LOW;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      tick_q    <= tick_d;
      pwm_cnt_q <= pwm_cnt_d;
      led_q     <= led_d;
    end
  end

  assign tick = tick_q;
  assign led  = led_q;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    mode_e               mode_q, mode_d;
    logic [15:0]         period_q, period_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic [15:0]         tcnt_q, tcnt_d;
    logic                lit_q, lit_d;
    logic [15:0]         p_eff;
    logic [15:0]         h_eff;
    logic                cfg_hit;
    logic                hb_on;
    logic                lit_now;

    // Out-of-range cfg_ch never matches any generated channel index.
    assign cfg_hit = cfg.cfg_we && (cfg.cfg_ch == CW'(gi));

    always_comb begin
      p_eff = (period_q == 16'd0) ? 16'd1 : period_q;
      h_eff = ((p_eff >> 3) == 16'd0) ? 16'd1 : (p_eff >> 3);
      hb_on = (tcnt_q < h_eff) ||
              ((tcnt_q >= (h_eff << 1)) && (tcnt_q < (h_eff * 16'd3)));
    end

    always_comb begin
      mode_d   = mode_q;
      period_d = period_q;
      duty_d   = duty_q;
      tcnt_d   = tcnt_q;
      lit_d    = lit_q;
      if (cfg_hit) begin
        // A write overrides any same-cycle tick or event on this channel.
        mode_d   = (cfg.cfg_mode > 3'd5) ? MODE_OFF : mode_e'(cfg.cfg_mode);
        period_d = cfg.cfg_period;
        duty_d   = cfg.cfg_duty;
        tcnt_d   = 16'd0;
        lit_d    = 1'b0;
      end else begin
        case (mode_q)
          MODE_BLINK: begin
            if (tick_q) begin
              if (tcnt_q >= p_eff - 16'd1) begin
                tcnt_d = 16'd0;
                lit_d  = ~lit_q;
              end else begin
                tcnt_d = tcnt_q + 16'd1;
              end
            end
          end
          MODE_PULSE: begin
            if (cfg.evt[gi]) begin
              tcnt_d = p_eff;
              lit_d  = 1'b1;
            end else if (tick_q && (tcnt_q != 16'd0)) begin
              tcnt_d = tcnt_q - 16'd1;
              if (tcnt_q == 16'd1) begin
                lit_d = 1'b0;
              end
            end
          end
          MODE_HBEAT: begin
            if (tick_q) begin
              tcnt_d = (tcnt_q >= p_eff - 16'd1) ? 16'd0 : tcnt_q + 16'd1;
            end
          end
          default: begin
          end
        endcase
      end
    end

    // Level for this cycle; led_q registers it one edge later.
    always_comb begin
      lit_now = 1'b0;
      case (mode_q)
        MODE_ON:                lit_now = 1'b1;
        MODE_BLINK, MODE_PULSE: lit_now = lit_q;
        MODE_PWM:               lit_now = (pwm_cnt_q < duty_q);
        MODE_HBEAT:             lit_now = hb_on;
        default:                lit_now = 1'b0;
      endcase
    end

    assign lit_w[gi] = lit_now;

    always_ff @(posedge clk) begin
      if (!rst_b) begin
        mode_q   <= MODE_OFF;
        period_q <= RST_PERIOD;
        duty_q   <= '0;
        tcnt_q   <= 16'd0;
        lit_q    <= 1'b0;
      end else begin
        mode_q   <= mode_d;
        period_q <= period_d;
        duty_q   <= duty_d;
        tcnt_q   <= tcnt_d;
        lit_q    <= lit_d;
      end
    end
  end

endmodule

// File: tb/tb_led_status_ctrl.sv
// Directed + random bench for led_status_ctrl, checked every cycle against an
// event-level model (ticks since configuration, remaining pulse ticks, cycle count).
module tb_led_status_ctrl;
  localparam int         N_CH = 3;
  localparam int         PWMB = 4;
  localparam int         DIV  = 10;
  localparam logic [2:0] AL   = 3'b010;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       tick;
  logic [2:0] led;

  led_status_ctrl_if #(.N_CH(N_CH), .PWM_BITS(PWMB)) cfg_if ();

  led_status_ctrl #(
    .N_CH(N_CH), .CLK_FREQ_HZ(100), .TICK_HZ(10), .PWM_BITS(PWMB),
    .ACTIVE_LOW(AL), .RST_PERIOD(16'd500)
  ) dut (
    .clk(clk), .rst_b(rst_b), .cfg(cfg_if), .tick(tick), .led(led)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: cyc = clock edges since last reset edge.
  int m_mode [N_CH];
  int m_per  [N_CH];
  int m_duty [N_CH];
  int m_ticks[N_CH];
  int m_rem  [N_CH];
  int cyc;
  logic [2:0] exp_led;
  logic       exp_tick;

  function automatic int eff_p(input int per);
    return (per == 0) ? 1 : per;
  endfunction

  function automatic logic model_lit(input int i);
    int p, h, t;
    p = eff_p(m_per[i]);
    case (m_mode[i])
      1: return 1'b1;
      2: return ((m_ticks[i] / p) % 2) == 1;
      3: return m_rem[i] > 0;
      4: return (cyc % 16) < m_duty[i];
      5: begin
        h = p / 8;
        if (h == 0) h = 1;
        t = m_ticks[i] % p;
        return (t < h) || (t >= 2 * h && t < 3 * h);
      end
      default: return 1'b0;
    endcase
  endfunction

  task automatic step(input string tag);
    logic tick_now;
    @(posedge clk);
    if (!rst_b) begin
      for (int i = 0; i < N_CH; i++) begin
        m_mode[i] = 0; m_per[i] = 500; m_duty[i] = 0; m_ticks[i] = 0; m_rem[i] = 0;
      end
      cyc = 0;
      exp_led = AL;
      exp_tick = 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) exp_led[i] = model_lit(i) ^ AL[i];
      tick_now = (cyc % DIV) == DIV - 1;
      for (int i = 0; i < N_CH; i++) begin
        if (cfg_if.cfg_we && int'(cfg_if.cfg_ch) == i) begin
          m_mode[i]  = (cfg_if.cfg_mode > 5) ? 0 : int'(cfg_if.cfg_mode);
          m_per[i]   = int'(cfg_if.cfg_period);
          m_duty[i]  = int'(cfg_if.cfg_duty);
          m_ticks[i] = 0;
          m_rem[i]   = 0;
        end else begin
          if (tick_now) begin
            m_ticks[i]++;
            if (m_rem[i] > 0) m_rem[i]--;
          end
          if (cfg_if.evt[i] && m_mode[i] == 3) m_rem[i] = eff_p(m_per[i]);
        end
      end
      cyc++;
      exp_tick = (cyc % DIV) == DIV - 1;
    end
    #1;
    tests++;
    assert (led === exp_led) else begin
      fails++;
      $error("FAIL %s led=%b expected %b (cyc %0d)", tag, led, exp_led, cyc);
    end
    tests++;
    assert (tick === exp_tick) else begin
      fails++;
      $error("FAIL %s tick=%b expected %b (cyc %0d)", tag, tick, exp_tick, cyc);
    end
    cfg_if.cfg_we = 1'b0;
    cfg_if.evt    = '0;
  endtask

  task automatic run(input int n, input string tag);
    for (int k = 0; k < n; k++) step(tag);
  endtask

  task automatic cfg_write(input int ch, input int mode, input int per, input int duty, input string tag);
    cfg_if.cfg_we     = 1'b1;
    cfg_if.cfg_ch     = 2'(ch);
    cfg_if.cfg_mode   = 3'(mode);
    cfg_if.cfg_period = 16'(per);
    cfg_if.cfg_duty   = 4'(duty);
    step(tag);
  endtask

  initial begin
    cfg_if.cfg_we = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_mode = '0;
    cfg_if.cfg_period = '0; cfg_if.cfg_duty = '0; cfg_if.evt = '0;

    rst_b = 1'b0;
    run(5, "reset");
    rst_b = 1'b1;
    run(35, "tick_start");

    cfg_write(0, 2, 3, 0, "blink_cfg");
    run(80, "blink_p3");
    cfg_write(0, 2, 0, 0, "blink_cfg0");
    run(45, "blink_p0");

    cfg_write(2, 3, 4, 0, "pulse_cfg");
    cfg_if.evt = 3'b100;
    step("pulse_evt1");
    run(20, "pulse_wait");
    cfg_if.evt = 3'b100;
    step("pulse_evt2");
    run(70, "pulse_retrig");
    cfg_write(1, 0, 4, 0, "off_cfg");
    cfg_if.evt = 3'b010;
    step("evt_in_off");
    run(5, "evt_in_off_hold");

    cfg_write(1, 4, 0, 4, "pwm_d4");
    run(40, "pwm_d4_run");
    cfg_write(1, 4, 0, 0, "pwm_d0");
    run(20, "pwm_d0_run");
    cfg_write(1, 4, 0, 15, "pwm_d15");
    run(40, "pwm_d15_run");

    cfg_write(0, 5, 16, 0, "hb_cfg");
    run(340, "hb_p16");

    cfg_write(2, 3, 4, 0, "pulse_rearm");
    cfg_if.evt = 3'b100;
    step("pulse_lit");
    cfg_if.evt = 3'b100;
    cfg_write(2, 3, 4, 0, "cfg_evt_collide");
    run(20, "collide_after");
    cfg_write(3, 1, 5, 5, "cfg_ch_oob");
    run(10, "oob_after");
    cfg_write(0, 2, 1, 0, "blink_p1");
    run(25, "blink_p1_run");
    rst_b = 1'b0;
    step("mid_reset");
    rst_b = 1'b1;
    run(15, "post_reset");

    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(15) == 0) begin
        cfg_if.cfg_we     = 1'b1;
        cfg_if.cfg_ch     = 2'($urandom_range(3));
        cfg_if.cfg_mode   = 3'($urandom_range(7));
        cfg_if.cfg_period = 16'($urandom_range(20));
        cfg_if.cfg_duty   = 4'($urandom_range(15));
      end
      for (int i = 0; i < N_CH; i++) cfg_if.evt[i] = ($urandom_range(7) == 0);
      rst_b = ($urandom_range(499) != 0);
      step("random");
    end
    rst_b = 1'b1;
    run(5, "random_tail");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/led_status_ctrl.md
# led_status_ctrl

Parametrised multi-channel status-LED driver for the board-controller FPGA. It replaces the free-running per-clock divider bits that drive SYSLED with per-channel programmable modes: off, on, blink, retriggerable event pulse, PWM dim and heartbeat. All timing is derived from one shared prescaler tick. The block sits in the system clock domain between the control/register logic and the SYSLED/TESTPIN outputs.

## Interface
Parameters:
- N_CH, 3, number of LED channels (1..16)
- CLK_FREQ_HZ, 156_250_000, frequency of clk in Hz
- TICK_HZ, 1000, prescaler tick rate; DIV = CLK_FREQ_HZ/TICK_HZ, must be ≥ 2
- PWM_BITS, 4, PWM duty resolution
- ACTIVE_LOW, {N_CH{1'b0}}, per-channel output polarity mask (bit = 1: LED lit when output low)
- RST_PERIOD, 16'd500, period loaded into every channel at reset

Ports:
- clk  in  1  system clock (clk156 at top level)
- rst_b  in  1  reset; one clock, reset is synchronous and active-low
- cfg_we  in  1  configuration write strobe, one cycle
- cfg_ch  in  CW=max(1,$clog2(N_CH))  target channel; values ≥ N_CH ignored
- cfg_mode  in  3  0 OFF, 1 ON, 2 BLINK, 3 PULSE, 4 PWM, 5 HEARTBEAT; 6/7 behave as OFF
- cfg_period  in  16  period in ticks (meaning per mode)
- cfg_duty  in  PWM_BITS  PWM duty
- evt  in  N_CH  per-channel event pulses (synchronous to clk), used in PULSE mode
- tick  out  1  one-cycle prescaler strobe
- led  out  N_CH  registered LED drive, polarity per ACTIVE_LOW

## Operation
- Prescaler: pre_cnt counts 0..DIV-1 and wraps. tick = 1 in the cycle pre_cnt == DIV-1.
- Per channel, the block holds mode, period, duty, a 16-bit tick counter tcnt and a lit bit. led[i] = lit[i] ^ ACTIVE_LOW[i], registered.
- Effective period p = (period == 0) ? 1 : period.
- A cfg write with cfg_ch < N_CH loads mode/period/duty and clears tcnt and lit for that channel. Other channels are unaffected.
- OFF: lit = 0. ON: lit = 1.
- BLINK: on each tick, tcnt increments. When tcnt == p-1, tcnt clears and lit toggles. Resulting period is 2·p ticks at 50 % duty.
- PULSE: evt[i] = 1 sets lit = 1 and loads tcnt = p. Each tick decrements tcnt; lit clears when tcnt reaches 0. Events are retriggerable (reload to p). evt is ignored in all other modes.
- PWM: a shared free-running PWM_BITS counter pwm_cnt advances every clk cycle (not tick). lit = (pwm_cnt < duty). duty 0 gives always off; max duty gives (2^PWM_BITS − 1)/2^PWM_BITS on.
- HEARTBEAT: frame of p ticks. tcnt increments on tick and wraps at p-1. lit = 1 when tcnt < h or (2h ≤ tcnt < 3h), where h = max(1, p>>3).
- Simultaneous events:
  - cfg write and evt to the same channel in the same cycle: the cfg write wins; evt is dropped.
  - cfg write and tick in the same cycle: the write wins; tcnt = 0 after the write.
- Arithmetic: tcnt comparisons are unsigned 16-bit; p>>3 is truncating.

## Timing
- Reset (rst_b sampled low at a clk edge):
  - pre_cnt = 0, tick = 0, pwm_cnt = 0
  - all modes OFF, period = RST_PERIOD, duty = 0, tcnt = 0, lit = 0
  - led = ACTIVE_LOW
- Reset asserted mid-operation behaves identically and aborts pulses and blinks immediately.
- First tick occurs DIV cycles after reset release (pre_cnt == DIV-1).
- cfg write at edge k: new state is visible at edge k+1; led reflects the new mode at edge k+1 (ON/OFF/PWM) or after the first qualifying tick (BLINK/HEARTBEAT).
- evt at edge k: led lit from edge k+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
Bench parameters: CLK_FREQ_HZ=100, TICK_HZ=10 (DIV=10), N_CH=3, ACTIVE_LOW=3'b010, PWM_BITS=4.
- Reset: hold rst_b low for 5 cycles, then release -> led = 3'b010 during and after reset; first tick pulse 10 cycles after release, then every 10 cycles.
- BLINK: ch0 mode 2, period 3 -> led[0] toggles every 30 cycles; period 0 -> toggles every 10 cycles.
- PULSE retrigger: ch2 mode 3, period 4; evt[2] pulsed, then pulsed again after 2 ticks -> led[2] stays lit for 6 ticks total, then clears; evt in OFF mode -> no change.
- PWM: ch1 duty 4 -> led[1] low (lit, active-low) for 4 of every 16 cycles; duty 0 -> led[1] constantly 1; duty 15 -> lit 15/16.
- HEARTBEAT: ch0 period 16 (h=2) -> lit during ticks 0–1 and 4–5 of each 16-tick frame.
- Collisions: cfg write and evt to ch2 in the same cycle -> evt dropped, lit = 0; cfg_ch = 3 -> no channel changes; rst_b low mid-blink -> led returns to 3'b010 on the next edge.
